// File: rtl/regfile_seq_pkg.sv
// Shared encodings for the register-file sequencer: ALU opcodes and FSM states.
package regfile_seq_pkg;

  localparam int unsigned OP_W    = 2;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational ALU for the sequencer: wrapping add/sub and bitwise and/or.
module regfile_seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  op_e           op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  // Add/sub deliberately drop the carry out: results wrap modulo 2^DW.
  always_comb begin
    y = '0;
    unique case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Single-command sequencer: read two registers, apply an ALU op, write the
// destination register (never r0) and return the result over a handshake.
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_rs,
  input  logic [AW-1:0] cmd_rt,
  input  logic [AW-1:0] cmd_rd,
  output logic [AW-1:0] rs,
  output logic [AW-1:0] rt,
  input  logic [DW-1:0] crs,
  input  logic [DW-1:0] crt,
  output logic [AW-1:0] rw,
  output logic [DW-1:0] dw,
  output logic          rwe,
  output logic          resp_valid,
  output logic [DW-1:0] resp_data,
  input  logic          resp_ready
);

  state_e        state, state_nxt;
  op_e           op_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] opa_q, opb_q, result_q;
  logic [DW-1:0] alu_y;

  logic accept_c, capture_c, exec_done_c, write_done_c, resp_done_c;

  regfile_seq_alu #(.DW(DW)) u_alu (
    .op (op_q),
    .a  (opa_q),
    .b  (opb_q),
    .y  (alu_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Fixed walk through the states; only IDLE and RESP can wait.
  always_comb begin
    state_nxt    = state;
    accept_c     = 1'b0;
    capture_c    = 1'b0;
    exec_done_c  = 1'b0;
    write_done_c = 1'b0;
    resp_done_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept_c  = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        capture_c = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        exec_done_c = 1'b1;
        state_nxt   = WRITE;
      end
      WRITE: begin
        write_done_c = 1'b1;
        state_nxt    = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_done_c = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read addresses are loaded at acceptance so they are already valid in READ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready  <= 1'b1;
      op_q       <= OP_ADD;
      rd_q       <= '0;
      rs         <= '0;
      rt         <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      result_q   <= '0;
      rw         <= '0;
      dw         <= '0;
      rwe        <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      if (accept_c) begin
        op_q      <= op_e'(cmd_op);
        rd_q      <= cmd_rd;
        rs        <= cmd_rs;
        rt        <= cmd_rt;
        cmd_ready <= 1'b0;
      end
      if (capture_c) begin
        opa_q <= crs;
        opb_q <= crt;
      end
      if (exec_done_c) begin
        result_q <= alu_y;
        rw       <= rd_q;
        dw       <= alu_y;
        rwe      <= (rd_q != '0);
      end
      if (write_done_c) begin
        rwe        <= 1'b0;
        resp_valid <= 1'b1;
        resp_data  <= result_q;
      end
      if (resp_done_c) begin
        resp_valid <= 1'b0;
        cmd_ready  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: attached register file, transaction-level
// reference model with per-cycle compare, plus directed literal checks.
module tb_regfile_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_rs, cmd_rt, cmd_rd;
  logic [AW-1:0] rs, rt, rw;
  logic [DW-1:0] crs, crt, dw, resp_data;
  logic          rwe, resp_valid, resp_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rs     (cmd_rs),
    .cmd_rt     (cmd_rt),
    .cmd_rd     (cmd_rd),
    .rs         (rs),
    .rt         (rt),
    .crs        (crs),
    .crt        (crt),
    .rw         (rw),
    .dw         (dw),
    .rwe        (rwe),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready)
  );

  // Register file with a bench-side preload port and combinational reads.
  logic [DW-1:0] regs [32];
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_wa = '0;
  logic [DW-1:0] tb_wd = '0;

  always @(posedge clk) begin
    if (tb_we)    regs[tb_wa] <= tb_wd;
    else if (rwe) regs[rw]    <= dw;
  end
  assign crs = regs[rs];
  assign crt = regs[rt];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_op(input logic [1:0] op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // Reference model: age = cycles since acceptance (-1 when idle).
  int            age = -1;
  int            cyc = 0;
  int            acc_cnt = 0;
  int            acc_last = 0;
  int            acc_prev = 0;
  logic [AW-1:0] m_rs, m_rt, m_rd;
  logic [DW-1:0] m_exp;
  logic [DW-1:0] mregs [32];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age = -1;
    end else begin
      cyc++;
      if (tb_we) mregs[tb_wa] = tb_wd;
      if (age < 0) begin
        if (cmd_valid) begin
          m_rs     = cmd_rs;
          m_rt     = cmd_rt;
          m_rd     = cmd_rd;
          m_exp    = ref_op(cmd_op, mregs[cmd_rs], mregs[cmd_rt]);
          age      = 1;
          acc_prev = acc_last;
          acc_last = cyc;
          acc_cnt++;
        end
      end else if (age >= 4) begin
        if (resp_ready) age = -1;
        else            age++;
      end else begin
        if (age == 3 && m_rd != '0) mregs[m_rd] = m_exp;
        age++;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  int            rwe_cnt = 0;
  logic [AW-1:0] last_rw = '0;
  logic [DW-1:0] last_dw = '0;
  logic [DW-1:0] last_resp = '0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmd_ready", 64'(cmd_ready), 64'(age < 0));
      chk("rwe", 64'(rwe), 64'(age == 3 && m_rd != '0));
      chk("resp_valid", 64'(resp_valid), 64'(age >= 4));
      if (age >= 1) begin
        chk("rs", 64'(rs), 64'(m_rs));
        chk("rt", 64'(rt), 64'(m_rt));
      end
      if (age == 3 && m_rd != '0) begin
        chk("rw", 64'(rw), 64'(m_rd));
        chk("dw", 64'(dw), 64'(m_exp));
      end
      if (age >= 4) chk("resp_data", 64'(resp_data), 64'(m_exp));
      if (rwe) begin
        rwe_cnt++;
        last_rw = rw;
        last_dw = dw;
      end
      if (resp_valid) last_resp = resp_data;
    end
  end

  task automatic poke(input int a, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    tb_wa = AW'(a);
    tb_wd = d;
    tb_we = 1'b1;
    @(posedge clk);
    #1;
    tb_we = 1'b0;
  endtask

  // Offer a command until accepted, then scramble cmd_* to show it is ignored.
  task automatic issue(input logic [1:0] op, input int a, input int b, input int d);
    int n;
    cmd_op    = op;
    cmd_rs    = AW'(a);
    cmd_rt    = AW'(b);
    cmd_rd    = AW'(d);
    cmd_valid = 1'b1;
    n = 0;
    while (age < 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(age >= 1), 64'(1));
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_rs    = AW'($urandom);
    cmd_rt    = AW'($urandom);
    cmd_rd    = AW'($urandom);
  endtask

  task automatic finish_cmd(input int hold);
    int n;
    resp_ready = 1'b0;
    n = 0;
    while (age < 4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("resp_timeout", 64'(age >= 4), 64'(1));
    repeat (hold) @(negedge clk);
    resp_ready = 1'b1;
    n = 0;
    while (age >= 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_timeout", 64'(age < 0), 64'(1));
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, n, a0;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_rs     = '0;
    cmd_rt     = '0;
    cmd_rd     = '0;
    resp_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("reset_rwe", 64'(rwe), 64'(0));
    chk("reset_resp_valid", 64'(resp_valid), 64'(0));
    chk("reset_rs", 64'(rs), 64'(0));
    chk("reset_rt", 64'(rt), 64'(0));
    chk("reset_rw", 64'(rw), 64'(0));
    chk("reset_dw", 64'(dw), 64'(0));
    chk("reset_resp_data", 64'(resp_data), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) poke(i, '0);

    // ADD r3 = r1 + r2, then read r3 back through the sequencer
    poke(1, 32'd5);
    poke(2, 32'd3);
    rc = rwe_cnt;
    issue(2'b00, 1, 2, 3);
    finish_cmd(0);
    chk("add_rwe_pulses", 64'(rwe_cnt - rc), 64'(1));
    chk("add_rw", 64'(last_rw), 64'(3));
    chk("add_dw", 64'(last_dw), 64'(8));
    chk("add_resp", 64'(last_resp), 64'(8));
    chk("add_r3", 64'(regs[3]), 64'(8));
    issue(2'b11, 3, 3, 0);
    finish_cmd(0);
    chk("r3_readback", 64'(last_resp), 64'(8));

    // SUB wraps
    poke(1, 32'd0);
    poke(2, 32'd1);
    issue(2'b01, 1, 2, 4);
    finish_cmd(1);
    chk("sub_dw", 64'(last_dw), 64'(32'hFFFF_FFFF));
    chk("sub_resp", 64'(last_resp), 64'(32'hFFFF_FFFF));
    chk("sub_r4", 64'(regs[4]), 64'(32'hFFFF_FFFF));

    // AND into r0: no write
    poke(1, 32'h0000_F0F0);
    poke(2, 32'h0000_FF00);
    rc = rwe_cnt;
    issue(2'b10, 1, 2, 0);
    finish_cmd(0);
    chk("and_rwe_pulses", 64'(rwe_cnt - rc), 64'(0));
    chk("and_resp", 64'(last_resp), 64'(32'h0000_F000));
    chk("and_r0", 64'(regs[0]), 64'(0));

    // OR with rs=rt=rd, response stalled for 4 cycles
    poke(5, 32'h0000_1234);
    rc = rwe_cnt;
    issue(2'b11, 5, 5, 5);
    finish_cmd(4);
    chk("or_rwe_pulses", 64'(rwe_cnt - rc), 64'(1));
    chk("or_resp", 64'(last_resp), 64'(32'h0000_1234));
    chk("or_r5", 64'(regs[5]), 64'(32'h0000_1234));

    // Reset during WRITE of ADD to r6
    poke(6, 32'h0000_0077);
    poke(1, 32'd5);
    poke(2, 32'd3);
    issue(2'b00, 1, 2, 6);
    n = 0;
    while (age != 3 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("write_state_timeout", 64'(age == 3), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("rst_rwe_async", 64'(rwe), 64'(0));
    chk("rst_cmd_ready_async", 64'(cmd_ready), 64'(1));
    chk("rst_resp_valid_async", 64'(resp_valid), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_r6_kept", 64'(regs[6]), 64'(32'h0000_0077));
    chk("rst_cmd_ready_after", 64'(cmd_ready), 64'(1));

    // Back-to-back commands with cmd_valid held high
    poke(1, 32'd5);
    poke(2, 32'd3);
    resp_ready = 1'b1;
    a0 = acc_cnt;
    cmd_op    = 2'b00;
    cmd_rs    = AW'(1);
    cmd_rt    = AW'(2);
    cmd_rd    = AW'(7);
    cmd_valid = 1'b1;
    n = 0;
    while (acc_cnt < a0 + 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    cmd_op = 2'b01;
    cmd_rs = AW'(7);
    cmd_rt = AW'(1);
    cmd_rd = AW'(8);
    n = 0;
    while (acc_cnt < a0 + 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_accept_count", 64'(acc_cnt - a0), 64'(2));
    cmd_valid = 1'b0;
    n = 0;
    while (age >= 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_timeout", 64'(age < 0), 64'(1));
    resp_ready = 1'b0;
    chk("b2b_spacing", 64'(acc_last - acc_prev), 64'(5));
    chk("b2b_r7", 64'(regs[7]), 64'(8));
    chk("b2b_r8", 64'(regs[8]), 64'(3));
    chk("b2b_last_resp", 64'(last_resp), 64'(3));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
